mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
Memory-access pipeline stage between execute and writeback.
- Accepts one instruction per handshake from the execute stage.
- Waits for the data-SRAM response when a memory request was issued in EX.
- Aligns and extends load data.
- Presents the 70-bit result bus and a valid signal to the writeback stage using the valid/allowin protocol.
- Buffers a response that arrives while writeback is stalled.

Parameters:
- ES_TO_MS_BUS_WD, 76, width of the execute-to-memory bus.
- MS_TO_WS_BUS_WD, 70, width of the memory-to-writeback bus.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high
- es_to_ms_valid  input  1  EX holds a valid instruction
- es_to_ms_bus  input  76  fields, MSB first:
  - mem_req [75]
  - ld_type [74:72]
  - addr_lo [71:70]
  - gr_we [69]
  - dest [68:64]
  - alu_result [63:32]
  - pc [31:0]
- ms_allowin  output  1  stage can accept this cycle
- ws_allowin  input  1  writeback can accept
- ms_to_ws_valid  output  1  result valid toward writeback
- ms_to_ws_bus  output  70  {gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}
- ms_to_ds_dest  output  5  dest of the held instruction, 0 when no valid instruction
- data_sram_data_ok  input  1  one-cycle pulse, response for the oldest outstanding request
- data_sram_rdata  input  32  read data, valid with data_ok

Behaviour:
- Reset (synchronous, active-high; clock clk):
  - ms_valid=0, state=EMPTY, buf_valid=0.
  - Outputs: ms_to_ws_valid=0, ms_to_ds_dest=0, ms_allowin=1.
- Capture: when es_to_ms_valid && ms_allowin, register the bus and set ms_valid.
- Invalidate: when ms_allowin && !es_to_ms_valid, clear ms_valid.
- ms_ready_go = !r_mem_req || buf_valid || data_sram_data_ok.
- ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
- ms_to_ws_valid = ms_valid && ms_ready_go.
- FSM:
  - EMPTY: ms_valid=0.
  - WAIT: valid with mem_req, no response yet.
  - DONE: result available.
- FSM transitions:
  - EMPTY -> WAIT on capture with mem_req=1.
  - EMPTY -> DONE on capture with mem_req=0.
  - WAIT -> DONE on data_ok while ws_allowin=0. Latch rdata into data_buf and set buf_valid.
  - WAIT -> EMPTY/WAIT/DONE on data_ok while ws_allowin=1. The result passes through combinationally the same cycle; the next state follows the new capture.
  - DONE -> next state when ws_allowin=1.
- buf_valid clears whenever the instruction leaves (ms_allowin=1).
- Load data source: buf_valid ? data_buf : data_sram_rdata. Shift right by addr_lo*8.
- ld_type decode:
  - 000: non-load, final_result = alu_result.
  - 001 ld.b: sign-extend byte.
  - 010 ld.h: sign-extend half, using addr_lo[1] only.
  - 011 ld.w: whole word, addr_lo ignored.
  - 100 ld.bu: zero-extend byte.
  - 101 ld.hu: zero-extend half.
  - 110/111: treated as 000.
- Stores carry mem_req=1, ld_type=000. They wait for data_ok and forward alu_result; rdata is ignored.
- ms_to_ds_dest = r_dest & {5{ms_valid}}, regardless of ready_go.
- Latency:
  - Non-memory instruction: 1 cycle EX->WB handshake.
  - Memory instruction: completes in the data_ok cycle.
- Boundaries:
  - data_ok while ms_valid=0 or in DONE: ignored, no state change.
  - Back-to-back loads: a new capture is allowed in the same cycle the previous load leaves.
  - Reset during WAIT: discards the instruction; the SRAM side is reset in the same cycle.
  - gr_we passes unmodified; writeback gates it with its own valid.

Optional Feature:
MS_FWD_DATA_EN
- Defined: adds output ms_to_ds_fwd (38 bits) = {fwd_valid, dest[4:0], final_result[31:0]}.
  - fwd_valid = ms_valid && ms_ready_go && r_gr_we && r_dest!=0.
  - Used for decode-stage bypass.
- Undefined: port absent; only ms_to_ds_dest is exported for stall-based interlock.

Test Plan:
- Non-memory instruction, ws_allowin=1: bus with alu_result=0x1234_5678, pc=0x1C00_0000, dest=5, gr_we=1 -> next cycle ms_to_ws_valid=1, bus={1,5,0x12345678,0x1C000000}, ms_to_ds_dest=5.
- ld.b with addr_lo=3, rdata=0x80FF_1122, data_ok 3 cycles after capture -> ms_to_ws_valid=0 for 2 cycles, then final_result=0xFFFF_FF80; ms_allowin=0 while waiting.
- ld.hu with addr_lo=2, rdata=0x8001_0000, data_ok while ws_allowin=0 -> buf_valid=1; after ws_allowin rises, final_result=0x0000_8001 and the instruction leaves the same cycle.
- Store (mem_req=1, ld_type=000) -> held until data_ok; final_result equals alu_result; a spurious data_ok while empty causes no output.
- Reset asserted in WAIT -> next cycle ms_to_ws_valid=0, ms_to_ds_dest=0, ms_allowin=1.
- With MS_FWD_DATA_EN, ld.w to dest 0 -> fwd_valid=0. ALU op to dest 7 -> fwd_valid=1 with data.

Source files
------------

// File: rtl/mem_stage_if.sv
// Handshake and bus bundle for the memory pipeline stage.
// The slave modport is the stage's own view; master is the surrounding
// pipeline (execute, writeback and data SRAM side).
// Optional feature macro: MS_FWD_DATA_EN adds the decode-stage bypass bus.
interface mem_stage_if #(
  parameter int ES_TO_MS_BUS_WD = 76,
  parameter int MS_TO_WS_BUS_WD = 70
);
  logic                       es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic                       ms_allowin;
  logic                       ws_allowin;
  logic                       ms_to_ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
  logic [4:0]                 ms_to_ds_dest;
  logic                       data_sram_data_ok;
  logic [31:0]                data_sram_rdata;
`ifdef MS_FWD_DATA_EN
  logic [37:0]                ms_to_ds_fwd;

  modport slave (
    input  es_to_ms_valid, es_to_ms_bus, ws_allowin,
           data_sram_data_ok, data_sram_rdata,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_dest,
           ms_to_ds_fwd
  );

  modport master (
    output es_to_ms_valid, es_to_ms_bus, ws_allowin,
           data_sram_data_ok, data_sram_rdata,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_dest,
           ms_to_ds_fwd
  );
`else
  modport slave (
    input  es_to_ms_valid, es_to_ms_bus, ws_allowin,
           data_sram_data_ok, data_sram_rdata,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_dest
  );

  modport master (
    output es_to_ms_valid, es_to_ms_bus, ws_allowin,
           data_sram_data_ok, data_sram_rdata,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_dest
  );
`endif
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage between execute and writeback.
// Holds one instruction, waits for the data-SRAM response when EX issued a
// request, aligns/extends load data and hands the result to writeback with
// the valid/allowin protocol. A response that arrives while writeback is
// stalled is kept in data_buf until the instruction can leave.
// Optional feature macro: MS_FWD_DATA_EN (decode-stage bypass bus).
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 76,
  parameter int MS_TO_WS_BUS_WD = 70
) (
  input  logic         clk,
  input  logic         reset,
  mem_stage_if.slave   mif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WAIT  = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_next;

  logic                       ms_valid;
  logic                       ms_ready_go;
  logic                       ms_allowin;
  logic [ES_TO_MS_BUS_WD-1:0] r_bus;
  logic                       buf_valid;
  logic [31:0]                data_buf;

  // Field views of the registered execute bus.
  logic        r_mem_req;
  logic [2:0]  r_ld_type;
  logic [1:0]  r_addr_lo;
  logic        r_gr_we;
  logic [4:0]  r_dest;
  logic [31:0] r_alu_result;
  logic [31:0] r_pc;

  assign r_mem_req    = r_bus[75];
  assign r_ld_type    = r_bus[74:72];
  assign r_addr_lo    = r_bus[71:70];
  assign r_gr_we      = r_bus[69];
  assign r_dest       = r_bus[68:64];
  assign r_alu_result = r_bus[63:32];
  assign r_pc         = r_bus[31:0];

  // Handshake: a memory instruction is ready once its response is buffered
  // or arriving this very cycle.
  assign ms_ready_go = !r_mem_req || buf_valid || mif.data_sram_data_ok;
  assign ms_allowin  = !ms_valid || (ms_ready_go && mif.ws_allowin);

  // Valid bit and response buffer; the buffer is only loaded from WAIT, so
  // responses while empty or already done are ignored.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      ms_valid  <= 1'b0;
      buf_valid <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid  <= mif.es_to_ms_valid;
      buf_valid <= 1'b0;
    end else if (state == WAIT && mif.data_sram_data_ok) begin
      buf_valid <= 1'b1;
    end
  end

  // Datapath registers: payload captured on handshake, response buffered on
  // a stalled data_ok.
  always_ff @(posedge clk) begin
    // NOTE: payload registers carry no reset; they are only observed while
    // ms_valid/buf_valid are set, and those flags are reset.
    if (mif.es_to_ms_valid && ms_allowin) begin
      r_bus <= mif.es_to_ms_bus;
    end
    if (!ms_allowin && state == WAIT && mif.data_sram_data_ok) begin
      data_buf <= mif.data_sram_rdata;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  // FSM next state: any departure reloads from the capture; a stalled
  // response moves WAIT to DONE.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_next unassigned,
    // which would infer a latch.
    state_next = state;
    if (ms_allowin) begin
      if (mif.es_to_ms_valid) begin
        state_next = mif.es_to_ms_bus[75] ? WAIT : DONE;
      end else begin
        state_next = EMPTY;
      end
    end else if (state == WAIT && mif.data_sram_data_ok) begin
      state_next = DONE;
    end
  end

  // Load alignment: pick the addressed byte/half of the response word.
  logic [31:0] ld_src;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] final_result;

  assign ld_src  = buf_valid ? data_buf : mif.data_sram_rdata;
  assign ld_half = r_addr_lo[1] ? ld_src[31:16] : ld_src[15:0];

  always_comb begin
    ld_byte = ld_src[7:0];
    case (r_addr_lo)
      2'd0: ld_byte = ld_src[7:0];
      2'd1: ld_byte = ld_src[15:8];
      2'd2: ld_byte = ld_src[23:16];
      2'd3: ld_byte = ld_src[31:24];
      default: ld_byte = ld_src[7:0];
    endcase
  end

  // Result select: extend loads, pass alu_result for everything else
  // (stores included).
  always_comb begin
    final_result = r_alu_result;
    case (r_ld_type)
      3'b001: final_result = {{24{ld_byte[7]}}, ld_byte};
      3'b010: final_result = {{16{ld_half[15]}}, ld_half};
      3'b011: final_result = ld_src;
      3'b100: final_result = {24'd0, ld_byte};
      3'b101: final_result = {16'd0, ld_half};
      default: final_result = r_alu_result;
    endcase
  end

  logic [MS_TO_WS_BUS_WD-1:0] ws_bus;
  assign ws_bus = {r_gr_we, r_dest, final_result, r_pc};

  assign mif.ms_allowin     = ms_allowin;
  assign mif.ms_to_ws_valid = ms_valid && ms_ready_go;
  assign mif.ms_to_ws_bus   = ws_bus;
  assign mif.ms_to_ds_dest  = r_dest & {5{ms_valid}};

`ifdef MS_FWD_DATA_EN
  logic fwd_valid;
  assign fwd_valid        = ms_valid && ms_ready_go && r_gr_we && (r_dest != 5'd0);
  assign mif.ms_to_ds_fwd = {fwd_valid, r_dest, final_result};
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a cycle-by-cycle vector table plus short
// hand-written sequences for reset during WAIT and the bypass bus.
module tb_mem_stage;

  logic clk;
  logic reset;

  mem_stage_if #(.ES_TO_MS_BUS_WD(76), .MS_TO_WS_BUS_WD(70)) mif ();

  mem_stage #(.ES_TO_MS_BUS_WD(76), .MS_TO_WS_BUS_WD(70)) u_dut (
    .clk   (clk),
    .reset (reset),
    .mif   (mif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [75:0] ex_bus(input logic mem_req, input logic [2:0] ld,
                                         input logic [1:0] lo, input logic we,
                                         input logic [4:0] dest, input logic [31:0] alu,
                                         input logic [31:0] pc);
    return {mem_req, ld, lo, we, dest, alu, pc};
  endfunction

  function automatic logic [69:0] wb_bus(input logic we, input logic [4:0] dest,
                                         input logic [31:0] res, input logic [31:0] pc);
    return {we, dest, res, pc};
  endfunction

  typedef struct {
    logic        es_valid;
    logic [75:0] bus;
    logic        ws_allowin;
    logic        data_ok;
    logic [31:0] rdata;
    logic        exp_allowin;
    logic        exp_valid;
    logic [69:0] exp_bus;
    logic [4:0]  exp_dest;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t row(input logic ev, input logic [75:0] b, input logic ws,
                               input logic ok, input logic [31:0] rd, input logic ea,
                               input logic evld, input logic [69:0] eb, input logic [4:0] ed);
    vec_t v;
    v.es_valid = ev; v.bus = b; v.ws_allowin = ws; v.data_ok = ok; v.rdata = rd;
    v.exp_allowin = ea; v.exp_valid = evld; v.exp_bus = eb; v.exp_dest = ed;
    return v;
  endfunction

  task automatic drive(input logic ev, input logic [75:0] b, input logic ws,
                       input logic ok, input logic [31:0] rd);
    mif.es_to_ms_valid    = ev;
    mif.es_to_ms_bus      = b;
    mif.ws_allowin        = ws;
    mif.data_sram_data_ok = ok;
    mif.data_sram_rdata   = rd;
  endtask

  logic [75:0] b_alu, b_lb, b_st, b_lh, b_lw, b_lbu, b_x6, b_lhu, b_lw0, b_alu7;
  logic [69:0] e_alu, e_lb, e_st, e_lh, e_lw, e_lbu, e_x6, e_lhu;

  initial begin
    b_alu = ex_bus(1'b0, 3'b000, 2'd0, 1'b1, 5'd5,  32'h1234_5678, 32'h1C00_0000);
    b_lb  = ex_bus(1'b1, 3'b001, 2'd3, 1'b1, 5'd6,  32'h0000_1003, 32'h1C00_0004);
    b_st  = ex_bus(1'b1, 3'b000, 2'd0, 1'b0, 5'd0,  32'hA000_0010, 32'h1C00_0008);
    b_lh  = ex_bus(1'b1, 3'b010, 2'd3, 1'b1, 5'd8,  32'h0000_1007, 32'h1C00_000C);
    b_lw  = ex_bus(1'b1, 3'b011, 2'd2, 1'b1, 5'd9,  32'h0000_1006, 32'h1C00_0010);
    b_lbu = ex_bus(1'b1, 3'b100, 2'd1, 1'b1, 5'd10, 32'h0000_1001, 32'h1C00_0014);
    b_x6  = ex_bus(1'b0, 3'b110, 2'd0, 1'b1, 5'd11, 32'hCAFE_F00D, 32'h1C00_0018);
    b_lhu = ex_bus(1'b1, 3'b101, 2'd2, 1'b1, 5'd12, 32'h0000_1002, 32'h1C00_001C);
    b_lw0 = ex_bus(1'b1, 3'b011, 2'd0, 1'b1, 5'd0,  32'h0000_2000, 32'h1C00_0020);
    b_alu7= ex_bus(1'b0, 3'b000, 2'd0, 1'b1, 5'd7,  32'h0BAD_F00D, 32'h1C00_0024);

    e_alu = wb_bus(1'b1, 5'd5,  32'h1234_5678, 32'h1C00_0000);
    e_lb  = wb_bus(1'b1, 5'd6,  32'hFFFF_FF80, 32'h1C00_0004);
    e_st  = wb_bus(1'b0, 5'd0,  32'hA000_0010, 32'h1C00_0008);
    e_lh  = wb_bus(1'b1, 5'd8,  32'hFFFF_8001, 32'h1C00_000C);
    e_lw  = wb_bus(1'b1, 5'd9,  32'h7654_3210, 32'h1C00_0010);
    e_lbu = wb_bus(1'b1, 5'd10, 32'h0000_00F1, 32'h1C00_0014);
    e_x6  = wb_bus(1'b1, 5'd11, 32'hCAFE_F00D, 32'h1C00_0018);
    e_lhu = wb_bus(1'b1, 5'd12, 32'h0000_8001, 32'h1C00_001C);

    // One row per cycle: inputs applied after the falling edge, outputs
    // compared before the next rising edge.
    //                  ev  bus    ws  ok  rdata          allow valid exp_bus dest
    vecs.push_back(row(0, '0,    1, 0, 32'h0,          1, 0, '0,    5'd0));  // idle
    vecs.push_back(row(1, b_alu, 1, 0, 32'h0,          1, 0, '0,    5'd0));  // capture ALU
    vecs.push_back(row(0, '0,    1, 0, 32'h0,          1, 1, e_alu, 5'd5));  // 1-cycle result
    vecs.push_back(row(1, b_lb,  1, 0, 32'h0,          1, 0, '0,    5'd0));  // capture ld.b
    vecs.push_back(row(0, '0,    1, 0, 32'h0,          0, 0, '0,    5'd6));  // wait 1
    vecs.push_back(row(0, '0,    1, 0, 32'h0,          0, 0, '0,    5'd6));  // wait 2
    vecs.push_back(row(1, b_st,  1, 1, 32'h80FF_1122,  1, 1, e_lb,  5'd6));  // data_ok, capture store
    vecs.push_back(row(0, '0,    1, 0, 32'h0,          0, 0, '0,    5'd0));  // store waits
    vecs.push_back(row(0, '0,    1, 1, 32'hDEAD_BEEF,  1, 1, e_st,  5'd0));  // store done
    vecs.push_back(row(0, '0,    1, 1, 32'h1234_5678,  1, 0, '0,    5'd0));  // spurious ok, empty
    vecs.push_back(row(1, b_lh,  1, 0, 32'h0,          1, 0, '0,    5'd0));  // capture ld.h
    vecs.push_back(row(1, b_lw,  1, 1, 32'h8001_7F00,  1, 1, e_lh,  5'd8));  // back-to-back
    vecs.push_back(row(1, b_lbu, 1, 1, 32'h7654_3210,  1, 1, e_lw,  5'd9));
    vecs.push_back(row(1, b_x6,  1, 1, 32'h0000_F100,  1, 1, e_lbu, 5'd10));
    vecs.push_back(row(0, '0,    0, 1, 32'hFFFF_FFFF,  0, 1, e_x6,  5'd11)); // DONE stalled, ok ignored
    vecs.push_back(row(0, '0,    1, 0, 32'h0,          1, 1, e_x6,  5'd11)); // leaves
    vecs.push_back(row(1, b_lhu, 1, 0, 32'h0,          1, 0, '0,    5'd0));  // capture ld.hu
    vecs.push_back(row(0, '0,    0, 1, 32'h8001_0000,  0, 1, e_lhu, 5'd12)); // ok while WB stalled
    vecs.push_back(row(0, '0,    0, 0, 32'hFFFF_FFFF,  0, 1, e_lhu, 5'd12)); // served from buffer
    vecs.push_back(row(0, '0,    1, 0, 32'hFFFF_FFFF,  1, 1, e_lhu, 5'd12)); // leaves same cycle
    vecs.push_back(row(0, '0,    1, 0, 32'h0,          1, 0, '0,    5'd0));  // empty again

    reset = 1'b1;
    drive(1'b0, '0, 1'b1, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    check("reset allowin", 70'(mif.ms_allowin), 70'(1));
    check("reset valid",   70'(mif.ms_to_ws_valid), 70'(0));
    check("reset dest",    70'(mif.ms_to_ds_dest), 70'(0));
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].es_valid, vecs[i].bus, vecs[i].ws_allowin, vecs[i].data_ok, vecs[i].rdata);
      #1;
      check($sformatf("row%0d allowin", i), 70'(mif.ms_allowin), 70'(vecs[i].exp_allowin));
      check($sformatf("row%0d valid", i), 70'(mif.ms_to_ws_valid), 70'(vecs[i].exp_valid));
      check($sformatf("row%0d dest", i), 70'(mif.ms_to_ds_dest), 70'(vecs[i].exp_dest));
      if (vecs[i].exp_valid)
        check($sformatf("row%0d bus", i), mif.ms_to_ws_bus, vecs[i].exp_bus);
    end

    // Reset while waiting for a load response discards the instruction.
    @(negedge clk);
    drive(1'b1, b_lb, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    drive(1'b0, '0, 1'b1, 1'b0, 32'h0);
    #1;
    check("wait allowin", 70'(mif.ms_allowin), 70'(0));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, '0, 1'b1, 1'b1, 32'h80FF_1122);
    #1;
    check("rst_wait valid",   70'(mif.ms_to_ws_valid), 70'(0));
    check("rst_wait dest",    70'(mif.ms_to_ds_dest), 70'(0));
    check("rst_wait allowin", 70'(mif.ms_allowin), 70'(1));

`ifdef MS_FWD_DATA_EN
    // ld.w to r0 must not forward; ALU op to r7 must.
    @(negedge clk);
    drive(1'b1, b_lw0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    drive(1'b1, b_alu7, 1'b1, 1'b1, 32'h1122_3344);
    #1;
    check("fwd ld r0 valid", 70'(mif.ms_to_ws_valid), 70'(1));
    check("fwd ld r0", 70'(mif.ms_to_ds_fwd), 70'({1'b0, 5'd0, 32'h1122_3344}));
    @(negedge clk);
    drive(1'b0, '0, 1'b1, 1'b0, 32'h0);
    #1;
    check("fwd alu r7", 70'(mif.ms_to_ds_fwd), 70'({1'b1, 5'd7, 32'h0BAD_F00D}));
`endif

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
